pipelined_wallace_mul: RTL and testbench

Parametrised, three-stage pipelined Wallace-tree multiplier for the multiply functional unit behind the reservation stations.
- Reduces WIDTH partial-product rows to two rows through levels of 3:2 carry-save adders, then finishes with a carry-propagate add.
- Supports unsigned and two's-complement operands, selected per operation.
- Carries the issuing reservation-station tag alongside each operation.
- Uses a valid/ready handshake on both sides, with full backpressure and a throughput of one operation per cycle.

---
 rtl/pipelined_wallace_mul.sv | 158 +++++++++++++++
 tb/tb_pipelined_wallace_mul.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_wallace_mul.sv
// Three-stage pipelined Wallace-tree multiplier (unsigned / Baugh-Wooley signed) with tag and valid/ready flow.
// Define MUL_FLUSH_EN to add the flush port that discards all in-flight operations.
module pipelined_wallace_mul #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef MUL_FLUSH_EN
    input  logic                 flush,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int unsigned P = 2 * WIDTH;

    function automatic int unsigned rows_after(input int unsigned lv);
        int unsigned n;
        n = WIDTH;
        for (int unsigned k = 0; k < lv; k++) n = 2 * (n / 3) + n % 3;
        return n;
    endfunction

    function automatic int unsigned level_count();
        int unsigned n;
        int unsigned cnt;
        n = WIDTH;
        cnt = 0;
        while (n > 2) begin
            n = 2 * (n / 3) + n % 3;
            cnt++;
        end
        return cnt;
    endfunction

    localparam int unsigned L  = level_count();
    localparam int unsigned H  = (L + 1) / 2;
    localparam int unsigned R1 = rows_after(H);

    logic                   flush_act;
    logic                   adv1, adv2, adv3, take_in;
    logic                   v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [WIDTH-1:0][P-1:0] pp;
    logic [R1-1:0][P-1:0]   s1_rows_q, s1_rows_d;
    logic [TAG_W-1:0]       s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d, out_tag_q, out_tag_d;
    logic [P-1:0]           s2_sum_q, s2_sum_d, s2_carry_q, s2_carry_d;
    logic [P-1:0]           out_product_q, out_product_d;

    // Baugh-Wooley constants sit in bit positions no shifted row occupies, so no extra row is needed.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp
        localparam logic [WIDTH-1:0] BW_INV = (gi == WIDTH - 1) ?
            {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
        localparam logic [P-1:0] BW_ONE =
            ((gi == 0) ? (P'(1) << WIDTH) : P'(0)) |
            ((gi == WIDTH - 1) ? (P'(1) << (P - 1)) : P'(0));
        logic [WIDTH-1:0] term;
        assign term   = (in_a & {WIDTH{in_b[gi]}}) ^ ({WIDTH{in_signed}} & BW_INV);
        assign pp[gi] = (P'(term) << gi) | ({P{in_signed}} & BW_ONE);
    end

    for (genvar g = 0; g < L; g++) begin : g_lvl
        localparam int unsigned N  = rows_after(g);
        localparam int unsigned T  = N / 3;
        localparam int unsigned NN = rows_after(g + 1);
        logic [N-1:0][P-1:0]  in_rows;
        logic [NN-1:0][P-1:0] out_rows;

        if (g == 0) begin : g_src_pp
            assign in_rows = pp;
        end else if (g == H) begin : g_src_reg
            assign in_rows = s1_rows_q;
        end else begin : g_src_prev
            assign in_rows = g_lvl[g-1].out_rows;
        end

        for (genvar t = 0; t < T; t++) begin : g_csa
            logic [P-1:0] x, y, z, maj;
            assign x   = in_rows[3*t];
            assign y   = in_rows[3*t+1];
            assign z   = in_rows[3*t+2];
            assign maj = (x & y) | (x & z) | (y & z);
            assign out_rows[2*t]   = x ^ y ^ z;
            assign out_rows[2*t+1] = {maj[P-2:0], 1'b0};
        end

        for (genvar r = 0; r < N - 3 * T; r++) begin : g_pass
            assign out_rows[2*T+r] = in_rows[3*T+r];
        end
    end

    always_comb begin
`ifdef MUL_FLUSH_EN
        flush_act = flush;
`else
        flush_act = 1'b0;
`endif
        adv3      = !v3_q | out_ready;
        adv2      = !v2_q | adv3;
        adv1      = !v1_q | adv2;
        in_ready  = adv1 & !rst & !flush_act;
        out_valid = v3_q & !flush_act;
        take_in   = in_valid & in_ready;

        v1_d = adv1 ? take_in : v1_q;
        v2_d = adv2 ? v1_q : v2_q;
        v3_d = adv3 ? v2_q : v3_q;
        if (flush_act) begin
            v1_d = 1'b0;
            v2_d = 1'b0;
            v3_d = 1'b0;
        end

        s1_rows_d     = take_in ? g_lvl[H-1].out_rows : s1_rows_q;
        s1_tag_d      = take_in ? in_tag : s1_tag_q;
        s2_sum_d      = (adv2 & v1_q) ? g_lvl[L-1].out_rows[0] : s2_sum_q;
        s2_carry_d    = (adv2 & v1_q) ? g_lvl[L-1].out_rows[1] : s2_carry_q;
        s2_tag_d      = (adv2 & v1_q) ? s1_tag_q : s2_tag_q;
        out_product_d = (adv3 & v2_q) ? s2_sum_q + s2_carry_q : out_product_q;
        out_tag_d     = (adv3 & v2_q) ? s2_tag_q : out_tag_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q          <= 1'b0;
            v2_q          <= 1'b0;
            v3_q          <= 1'b0;
            out_product_q <= '0;
            out_tag_q     <= '0;
        end else begin
            v1_q          <= v1_d;
            v2_q          <= v2_d;
            v3_q          <= v3_d;
            out_product_q <= out_product_d;
            out_tag_q     <= out_tag_d;
        end
    end

    always_ff @(posedge clk) begin
        s1_rows_q  <= s1_rows_d;
        s1_tag_q   <= s1_tag_d;
        s2_sum_q   <= s2_sum_d;
        s2_carry_q <= s2_carry_d;
        s2_tag_q   <= s2_tag_d;
    end

    assign out_product = out_product_q;
    assign out_tag     = out_tag_q;

endmodule

// File: tb/tb_pipelined_wallace_mul.sv
// Self-checking bench for pipelined_wallace_mul: directed corners plus random traffic against an arithmetic model.
module tb_pipelined_wallace_mul;

    localparam int unsigned W  = 32;
    localparam int unsigned TW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_ready, in_signed;
    logic [W-1:0]    in_a, in_b;
    logic [TW-1:0]   in_tag, out_tag;
    logic            out_valid, out_ready;
    logic [2*W-1:0]  out_product;
`ifdef MUL_FLUSH_EN
    logic            flush;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [63:0] p;
        logic [3:0]  t;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   out_hist[$];

    always #5 clk = ~clk;

    pipelined_wallace_mul #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef MUL_FLUSH_EN
        .flush       (flush),
`endif
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_signed   (in_signed),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_tag     (out_tag)
    );

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (s) return 64'(longint'($signed(a)) * longint'($signed(b)));
        return 64'(a) * 64'(b);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transfers happen at the next rising edge; inputs are stable between this edge and that one.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (out_valid && out_ready) begin
                out_hist.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("spurious_out", 64'(out_valid), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("product", out_product, mon_e.p);
                    check("tag", 64'(out_tag), 64'(mon_e.t));
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back('{p: ref_mul(in_a, in_b, in_signed), t: in_tag});
        end
    end

    task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                            input logic [3:0] t, output int waits);
        logic done;
        done = 1'b0;
        waits = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_signed = s; in_tag = t;
        while (!done) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            if (!done) begin
                waits++;
                if (waits >= 50) begin
                    check("accept_timeout", 64'd1, 64'd0);
                    done = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic await_out(output logic [63:0] p, output logic [3:0] t, output int n);
        n = 0;
        while (n < 30) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
        end
        if (!out_valid) check("out_timeout", 64'd0, 64'd1);
        p = out_product;
        t = out_tag;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    logic [63:0] p, hp;
    logic [3:0]  t, ht;
    int          n, w, acc;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0;
        out_ready = 1'b1;
`ifdef MUL_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        check("post_rst_product", out_product, 64'd0);
        check("post_rst_tag", 64'(out_tag), 64'd0);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        drive_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd3, w);
        await_out(p, t, n);
        check("corner_latency", 64'(n), 64'd3);
        check("corner_product", p, 64'hFFFF_FFFE_0000_0001);
        check("corner_tag", 64'(t), 64'd3);
        wait_drain();

        drive_op(32'hFFFF_FFFE, 32'd3, 1'b1, 4'd1, w);
        await_out(p, t, n);
        check("signed_m2x3", p, 64'hFFFF_FFFF_FFFF_FFFA);
        drive_op(32'h8000_0000, 32'h8000_0000, 1'b1, 4'd2, w);
        await_out(p, t, n);
        check("signed_min_sq", p, 64'h4000_0000_0000_0000);
        wait_drain();

        out_hist.delete();
        for (int i = 0; i < 10; i++) begin
            drive_op($urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), w);
            check("b2b_accept_wait", 64'(w), 64'd0);
        end
        wait_drain();
        check("b2b_count", 64'(out_hist.size()), 64'd10);
        if (out_hist.size() == 10)
            check("b2b_consecutive", 64'(out_hist[9] - out_hist[0]), 64'd9);

        out_ready = 1'b0;
        acc = 0;
        in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
        in_signed = 1'($urandom_range(0, 1)); in_tag = 4'($urandom_range(0, 15));
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 3) begin
                check("bp_ready_open", 64'(in_ready), 64'd1);
            end else begin
                check("bp_ready_closed", 64'(in_ready), 64'd0);
                check("bp_out_valid", 64'(out_valid), 64'd1);
                if (c == 3) begin
                    hp = out_product;
                    ht = out_tag;
                end else begin
                    check("bp_product_stable", out_product, hp);
                    check("bp_tag_stable", 64'(out_tag), 64'(ht));
                end
            end
            if (in_ready) acc++;
            @(posedge clk); #1;
            in_a = $urandom; in_b = $urandom;
            in_signed = 1'($urandom_range(0, 1)); in_tag = 4'($urandom_range(0, 15));
        end
        check("bp_accepts", 64'(acc), 64'd3);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_drain_valid", 64'(out_valid), 64'd1);
        end
        @(negedge clk);
        check("bp_drained_valid", 64'(out_valid), 64'd0);
        check("bp_drained_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        drive_op($urandom, $urandom, 1'b0, 4'd6, w);
        drive_op($urandom, $urandom, 1'b1, 4'd7, w);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("rst_mid_in_ready", 64'(in_ready), 64'd0);
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) check("rst_mid_ready_after", 64'(in_ready), 64'd1);
            check("rst_mid_no_out", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        drive_op(32'd7, 32'd6, 1'b0, 4'd5, w);
        await_out(p, t, n);
        check("rst_mid_7x6", p, 64'd42);
        check("rst_mid_tag", 64'(t), 64'd5);
        wait_drain();

`ifdef MUL_FLUSH_EN
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            drive_op($urandom, $urandom, 1'($urandom_range(0, 1)), 4'(i), w);
        flush = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("flush_after_valid", 64'(out_valid), 64'd0);
        check("flush_after_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        drive_op(32'd5, 32'd5, 1'b0, 4'd9, w);
        await_out(p, t, n);
        check("flush_5x5", p, 64'd25);
        check("flush_tag", 64'(t), 64'd9);
        wait_drain();
`endif

        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = $urandom;
            in_b      = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            in_signed = 1'($urandom_range(0, 1));
            in_tag    = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
